jt89_bus_wr: RTL and testbench
==============================

Name: jt89_bus_wr

Overview:
- CPU-side write decoder for the JT89 PSG.
- Accepts SN76489-format byte writes (latch/data bytes) on an 8-bit bus.
- Holds all channel registers: three 10-bit tone periods, four 4-bit attenuations, 3-bit noise control.
- Drives the tone, noise and volume generators, including the one-cycle `clr` pulse that reseeds the noise LFSR. Also drives the chip READY handshake back to the CPU.

Parameters:
- READY_CYC, 32, number of `clk_en` ticks READY stays low after an accepted write (valid range 1-255).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- clk_en  in  1  PSG clock enable (same enable fed to the generators)
- cs_n  in  1  chip select, active low
- wr_n  in  1  write strobe, active low, level from CPU
- din  in  8  CPU data byte
- ready  out  1  high = chip can accept a write
- tone0  out  10  channel 0 period
- tone1  out  10  channel 1 period
- tone2  out  10  channel 2 period (also noise rate source when ctrl3[1:0]=3)
- vol0  out  4  channel 0 attenuation (F = silent)
- vol1  out  4  channel 1 attenuation
- vol2  out  4  channel 2 attenuation
- vol3  out  4  noise attenuation
- ctrl3  out  3  noise control: bit2 white/periodic, bits1:0 rate
- clr  out  1  one-clk pulse: reseed noise LFSR

Behaviour:
- Reset values:
  - tone0/1/2 = 0; vol0..3 = 4'hF; ctrl3 = 0; clr = 0; ready = 1.
  - Latched register index = 0, latched type = tone.
  - Internal `wr_n_d` = 1; ready counter = 0.
- Write detection:
  - `wr_n` is registered every `clk` into `wr_n_d`.
  - An accepted write occurs in cycle N when `wr_n_d`=1, `wr_n`=0, `cs_n`=0 and `ready`=1.
  - Detection does not depend on `clk_en`. `din` is sampled in cycle N.
  - A falling edge while `ready`=0 or `cs_n`=1 is dropped; no register changes.
- Latch byte (din[7]=1):
  - idx = din[6:5] and typ = din[4] are stored.
  - typ=1: vol[idx] = din[3:0].
  - typ=0, idx<3: tone[idx][3:0] = din[3:0]; tone[idx][9:4] unchanged.
  - typ=0, idx=3: ctrl3 = din[2:0]; clr pulses.
- Data byte (din[7]=0), using the stored idx/typ:
  - typ=1: vol[idx] = din[3:0].
  - typ=0, idx<3: tone[idx][9:4] = din[5:0].
  - typ=0, idx=3: ctrl3 = din[2:0]; clr pulses.
- Latency:
  - Register outputs update on the clock edge ending cycle N, i.e. visible from N+1.
  - `clr` is high for exactly cycle N+1, then low. It is never asserted by a volume or tone write.
- READY:
  - On an accepted write, ready = 0 from N+1 and the counter loads READY_CYC.
  - While ready=0 the counter decrements on each `clk_en`. When the counter is 1 and `clk_en` is high, the counter goes to 0 and ready = 1 on the next cycle.
  - If `clk_en` is stuck low, ready stays low indefinitely.
- Boundaries:
  - Reset mid-busy: ready = 1 and counter = 0 immediately (next edge); any pending `clr` is cancelled.
  - `wr_n` held low across the end of busy: no new write, because an edge is required.
  - Data byte after reset with no prior latch targets tone0[9:4].
  - Simultaneous rst and write: rst wins.

Optional Feature:
- Macro JT89_GG_STEREO_EN.
- When defined:
  - Adds input `gg_cs_n` (1 bit) and output `stereo` (8 bits, reset 8'hFF).
  - A falling `wr_n` edge with `gg_cs_n`=0 and `cs_n`=1 writes `stereo` = din.
  - This write does not affect `ready`, the latch state or `clr`.
  - `cs_n` and `gg_cs_n` both low: the PSG write takes priority and `stereo` is unchanged.
- When undefined: neither port exists, and behaviour is exactly as above.

Test Plan:
- Reset, then idle -> vol0..3=F, tones=0, ctrl3=0, ready=1, clr never high.
- Write 8'h8A then 8'h3F -> tone0=10'h3FA. ready low from the first write for 32 clk_en ticks, so the second write is only accepted after ready returns high. Second write issued early -> dropped, tone0 stays 10'h00A.
- Write 8'hE5 -> ctrl3=3'b101, clr high exactly one clk at N+1. Then data byte 8'h06 -> ctrl3=3'b110, clr pulses again.
- Write 8'hD3 then (after ready) 8'h07 -> vol2 goes 3 then 7. tone2 unchanged, no clr.
- Assert rst while ready=0 with counter mid-count -> next cycle ready=1. A new write is accepted immediately after rst deasserts.
- JT89_GG_STEREO_EN: gg_cs_n=0, cs_n=1, din=8'h5A -> stereo=8'h5A, ready stays 1. Both selects low with din=8'h9F -> vol0=F, stereo unchanged.

Source files
------------

// File: rtl/jt89_bus_wr.sv
// JT89 CPU write decoder: SN76489 latch/data byte decoding, channel registers and READY handshake.
// Optional Game Gear stereo register enabled by defining JT89_GG_STEREO_EN.
module jt89_bus_wr #(
  parameter int READY_CYC = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic [7:0] din,
  output logic       ready,
  output logic [9:0] tone0,
  output logic [9:0] tone1,
  output logic [9:0] tone2,
  output logic [3:0] vol0,
  output logic [3:0] vol1,
  output logic [3:0] vol2,
  output logic [3:0] vol3,
  output logic [2:0] ctrl3,
  output logic       clr
`ifdef JT89_GG_STEREO_EN
  ,
  input  logic       gg_cs_n,
  output logic [7:0] stereo
`endif
);

  localparam logic [7:0] READY_LOAD = 8'(READY_CYC);

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } st_t;

  st_t        st, st_nx;
  logic       wr_n_d;
  logic [7:0] cnt;
  logic [1:0] idx_r;
  logic       typ_r;
  logic       wr_fall;
  logic       psg_wr;
  logic [1:0] idx_eff;
  logic       typ_eff;
  logic       noise_wr;
  logic [9:0] tone0_r, tone1_r, tone2_r;
  logic [3:0] vol0_r, vol1_r, vol2_r, vol3_r;
  logic [2:0] ctrl3_r;
  logic       clr_r;

  // A latch byte carries 4 low period bits, a data byte carries the 6 high bits.
  function automatic logic [9:0] tone_upd(input logic [9:0] cur, input logic [7:0] d);
    if (d[7]) return {cur[9:4], d[3:0]};
    else      return {d[5:0], cur[3:0]};
  endfunction

  assign wr_fall = wr_n_d & ~wr_n;
  assign psg_wr  = wr_fall & ~cs_n & ready;

  // Latch bytes address themselves; data bytes reuse the stored target.
  always_comb begin
    idx_eff = idx_r;
    typ_eff = typ_r;
    if (din[7]) begin
      idx_eff = din[6:5];
      typ_eff = din[4];
    end
  end

  assign noise_wr = psg_wr & ~typ_eff & (idx_eff == 2'd3);

  // READY handshake state
  always_ff @(posedge clk) begin
    if (rst) begin
      st     <= ST_IDLE;
      wr_n_d <= 1'b1;
    end else begin
      st     <= st_nx;
      wr_n_d <= wr_n;
    end
  end

  always_comb begin
    st_nx = st;
    ready = 1'b0;
    case (st)
      ST_IDLE: begin
        ready = 1'b1;
        if (psg_wr) st_nx = ST_BUSY;
      end
      ST_BUSY: begin
        if (clk_en && cnt == 8'd1) st_nx = ST_IDLE;
      end
      default: st_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 8'd0;
    end else if (psg_wr) begin
      cnt <= READY_LOAD;
    end else if (st == ST_BUSY && clk_en && cnt != 8'd0) begin
      cnt <= cnt - 8'd1;
    end
  end

  // Latched target and channel registers, updated at the end of the write cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r   <= 2'd0;
      typ_r   <= 1'b0;
      tone0_r <= 10'd0;
      tone1_r <= 10'd0;
      tone2_r <= 10'd0;
      vol0_r  <= 4'hF;
      vol1_r  <= 4'hF;
      vol2_r  <= 4'hF;
      vol3_r  <= 4'hF;
      ctrl3_r <= 3'd0;
      clr_r   <= 1'b0;
    end else begin
      clr_r <= noise_wr;
      if (psg_wr) begin
        idx_r <= idx_eff;
        typ_r <= typ_eff;
        if (typ_eff) begin
          case (idx_eff)
            2'd0:    vol0_r <= din[3:0];
            2'd1:    vol1_r <= din[3:0];
            2'd2:    vol2_r <= din[3:0];
            default: vol3_r <= din[3:0];
          endcase
        end else begin
          case (idx_eff)
            2'd0:    tone0_r <= tone_upd(tone0_r, din);
            2'd1:    tone1_r <= tone_upd(tone1_r, din);
            2'd2:    tone2_r <= tone_upd(tone2_r, din);
            default: ctrl3_r <= din[2:0];
          endcase
        end
      end
    end
  end

`ifdef JT89_GG_STEREO_EN
  // PSG select wins when both selects are low.
  logic gg_wr;
  assign gg_wr = wr_fall & ~gg_cs_n & cs_n;

  always_ff @(posedge clk) begin
    if (rst)        stereo <= 8'hFF;
    else if (gg_wr) stereo <= din;
  end
`endif

  assign tone0 = tone0_r;
  assign tone1 = tone1_r;
  assign tone2 = tone2_r;
  assign vol0  = vol0_r;
  assign vol1  = vol1_r;
  assign vol2  = vol2_r;
  assign vol3  = vol3_r;
  assign ctrl3 = ctrl3_r;
  assign clr   = clr_r;

endmodule

// File: tb/tb_jt89_bus_wr.sv
// Directed self-checking bench for jt89_bus_wr (optional JT89_GG_STEREO_EN section).
module tb_jt89_bus_wr;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk_en = 1'b1;
  logic       cs_n = 1'b1;
  logic       wr_n = 1'b1;
  logic [7:0] din = 8'h00;
  logic       ready;
  logic [9:0] tone0, tone1, tone2;
  logic [3:0] vol0, vol1, vol2, vol3;
  logic [2:0] ctrl3;
  logic       clr;
`ifdef JT89_GG_STEREO_EN
  logic       gg_cs_n = 1'b1;
  logic [7:0] stereo;
`endif

  int tests = 0;
  int fails = 0;
  int n;

  always #5 clk = ~clk;

  jt89_bus_wr #(.READY_CYC(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .cs_n   (cs_n),
    .wr_n   (wr_n),
    .din    (din),
    .ready  (ready),
    .tone0  (tone0),
    .tone1  (tone1),
    .tone2  (tone2),
    .vol0   (vol0),
    .vol1   (vol1),
    .vol2   (vol2),
    .vol3   (vol3),
    .ctrl3  (ctrl3),
    .clr    (clr)
`ifdef JT89_GG_STEREO_EN
    ,
    .gg_cs_n(gg_cs_n),
    .stereo (stereo)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle write strobe; returns #1 after the edge ending the write cycle.
  task automatic wr_byte(input logic [7:0] b);
    @(posedge clk); #1;
    cs_n = 1'b0; wr_n = 1'b0; din = b;
    @(posedge clk); #1;
    cs_n = 1'b1; wr_n = 1'b1;
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (!ready && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_vol0", 16'(vol0), 16'hF);
    chk("rst_vol1", 16'(vol1), 16'hF);
    chk("rst_vol2", 16'(vol2), 16'hF);
    chk("rst_vol3", 16'(vol3), 16'hF);
    chk("rst_tone0", 16'(tone0), 16'h0);
    chk("rst_tone1", 16'(tone1), 16'h0);
    chk("rst_tone2", 16'(tone2), 16'h0);
    chk("rst_ctrl3", 16'(ctrl3), 16'h0);
    chk("rst_ready", 16'(ready), 16'h1);
    chk("rst_clr", 16'(clr), 16'h0);

    // Tone 0 latch, early data byte dropped, then accepted
    wr_byte(8'h8A);
    chk("t0_lo", 16'(tone0), 16'h00A);
    chk("t0_busy", 16'(ready), 16'h0);
    chk("t0_noclr", 16'(clr), 16'h0);
    wr_byte(8'h3F);
    chk("t0_drop", 16'(tone0), 16'h00A);
    wait_ready(n);
    chk("t0_busy_len", 16'(n), 16'd30);
    wr_byte(8'h3F);
    chk("t0_full", 16'(tone0), 16'h3FA);
    wait_ready(n);
    chk("t0_busy_len2", 16'(n), 16'd32);

    // Noise control latch and data, each pulsing clr for one cycle
    wr_byte(8'hE5);
    chk("nz_ctrl_l", 16'(ctrl3), 16'h5);
    chk("nz_clr_l", 16'(clr), 16'h1);
    @(posedge clk); #1;
    chk("nz_clr_l_off", 16'(clr), 16'h0);
    wait_ready(n);
    wr_byte(8'h06);
    chk("nz_ctrl_d", 16'(ctrl3), 16'h6);
    chk("nz_clr_d", 16'(clr), 16'h1);
    @(posedge clk); #1;
    chk("nz_clr_d_off", 16'(clr), 16'h0);
    wait_ready(n);

    // Volume 2 latch and data; tone 2 untouched
    wr_byte(8'hD3);
    chk("v2_l", 16'(vol2), 16'h3);
    chk("v2_l_clr", 16'(clr), 16'h0);
    wait_ready(n);
    wr_byte(8'h07);
    chk("v2_d", 16'(vol2), 16'h7);
    chk("v2_tone2", 16'(tone2), 16'h0);
    chk("v2_d_clr", 16'(clr), 16'h0);
    wait_ready(n);

    // wr_n held low across the end of busy: no second write
    @(posedge clk); #1;
    cs_n = 1'b0; wr_n = 1'b0; din = 8'hA7;
    @(posedge clk); #1;
    chk("t1_lo", 16'(tone1), 16'h007);
    din = 8'h3C;
    wait_ready(n);
    repeat (3) @(posedge clk); #1;
    chk("hold_low_t1", 16'(tone1), 16'h007);
    chk("hold_low_ready", 16'(ready), 16'h1);
    cs_n = 1'b1; wr_n = 1'b1;

    // clk_en stuck low keeps READY low
    wr_byte(8'h95);
    chk("v0_5", 16'(vol0), 16'h5);
    clk_en = 1'b0;
    repeat (50) @(posedge clk); #1;
    chk("stuck_busy", 16'(ready), 16'h0);
    clk_en = 1'b1;
    wait_ready(n);
    chk("stuck_resume_len", 16'(n), 16'd32);

    // Reset mid-busy with a clr pulse pending
    wr_byte(8'hE4);
    chk("pre_rst_clr", 16'(clr), 16'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_ready", 16'(ready), 16'h1);
    chk("mid_rst_clr", 16'(clr), 16'h0);
    chk("mid_rst_ctrl3", 16'(ctrl3), 16'h0);
    chk("mid_rst_vol0", 16'(vol0), 16'hF);

    // Data byte with no prior latch goes to tone0[9:4], accepted right away
    wr_byte(8'h21);
    chk("post_rst_t0", 16'(tone0), 16'h210);
    chk("post_rst_busy", 16'(ready), 16'h0);
    wait_ready(n);

    // Reset and write in the same cycle: reset wins
    @(posedge clk); #1;
    rst = 1'b1; cs_n = 1'b0; wr_n = 1'b0; din = 8'h90;
    @(posedge clk); #1;
    rst = 1'b0; cs_n = 1'b1; wr_n = 1'b1;
    chk("rst_wr_vol0", 16'(vol0), 16'hF);
    chk("rst_wr_ready", 16'(ready), 16'h1);
    chk("rst_wr_t0", 16'(tone0), 16'h000);

`ifdef JT89_GG_STEREO_EN
    @(posedge clk); #1;
    chk("gg_rst", 16'(stereo), 16'hFF);
    gg_cs_n = 1'b0; wr_n = 1'b0; din = 8'h5A;
    @(posedge clk); #1;
    gg_cs_n = 1'b1; wr_n = 1'b1;
    chk("gg_stereo", 16'(stereo), 16'h5A);
    chk("gg_ready", 16'(ready), 16'h1);
    @(posedge clk); #1;
    gg_cs_n = 1'b0; cs_n = 1'b0; wr_n = 1'b0; din = 8'h93;
    @(posedge clk); #1;
    gg_cs_n = 1'b1; cs_n = 1'b1; wr_n = 1'b1;
    chk("gg_both_vol0", 16'(vol0), 16'h3);
    chk("gg_both_stereo", 16'(stereo), 16'h5A);
    chk("gg_both_busy", 16'(ready), 16'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
